// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction-fetch front end for the MIPS CPU.
//
// Owns the PC, issues one sequential word fetch per cycle to a synchronous
// instruction ROM with 1-cycle read latency, and buffers each returned
// instruction together with its PC in a DEPTH-entry FIFO. Decode drains the
// FIFO over a valid/ready handshake. A redirect from execute flushes the FIFO
// and discards the fetch that is still in flight.
//
// Optional build macro: IFQ_PREDECODE_JUMP_EN
//   When defined, j/jal instructions are recognised as they are pushed, and
//   fetch restarts at the jump target in the same edge.
//
// Parameters:
//   ADDR_W   PC width in bits
//   ROM_AW   ROM word-address width (imem_addr = fetch_pc[ROM_AW+1:2])
//   DEPTH    FIFO entries, power of two, >= 2
//   RESET_PC PC loaded on reset, word aligned
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   redirect_valid/_pc  taken branch/jr from execute (pc bits [1:0] ignored)
//   imem_req/_addr      fetch request and ROM word address
//   imem_rdata          ROM data, valid the cycle after imem_req
//   out_valid/_ready    handshake towards decode
//   out_instr/_pc       head instruction and its PC
//   out_pc_plus4        head PC + 4
module ifetch_queue #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ROM_AW   = 14,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ROM_AW-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus4
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // Architectural state
  logic [ADDR_W-1:0] fetch_pc;
  logic              epoch;
  logic              inflight;
  logic              infl_tag;
  logic [ADDR_W-1:0] infl_pc;

  // FIFO storage and bookkeeping
  logic [31:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [CNT_W:0]    occupancy;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_aligned;

  // Masking instead of slicing keeps every redirect_pc bit in use.
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // Credit check counts the outstanding fetch but ignores a same-cycle pop,
  // so a push can never find the FIFO full.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign imem_req  = !reset && !redirect_valid &&
                     (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_addr = fetch_pc[ROM_AW+1:2];

  // A return belongs to the current stream only if its epoch tag matches.
  assign push = inflight && (infl_tag == epoch) && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign out_valid    = (count != '0);
  assign out_instr    = instr_q[rd_ptr];
  assign out_pc       = pc_q[rd_ptr];
  assign out_pc_plus4 = out_pc + ADDR_W'(4);

`ifdef IFQ_PREDECODE_JUMP_EN
  logic [ADDR_W-1:0] ret_pc_plus4;
  logic [ADDR_W-1:0] jump_target;
  logic              jump_hit;

  assign ret_pc_plus4 = infl_pc + ADDR_W'(4);
  // Opcodes 000010 (j) and 000011 (jal) share the upper five bits.
  assign jump_hit     = push && (imem_rdata[31:27] == 5'b00001);
  // Region bits above bit 27 come from pc+4; mask form stays legal for
  // PC widths below 28 bits.
  assign jump_target  = (ret_pc_plus4 & ~ADDR_W'(32'h0FFF_FFFF)) |
                        ADDR_W'({imem_rdata[25:0], 2'b00});
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= ADDR_W'(RESET_PC);
      epoch    <= 1'b0;
      inflight <= 1'b0;
      infl_tag <= 1'b0;
      infl_pc  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: FIFO emptied, outstanding return orphaned by the epoch flip.
      fetch_pc <= redirect_aligned;
      epoch    <= ~epoch;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        infl_tag <= epoch;
        infl_pc  <= fetch_pc;
      end

      if (push) begin
        instr_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr]    <= infl_pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

`ifdef IFQ_PREDECODE_JUMP_EN
      // Overrides the sequential PC update above; the fetch issued this
      // cycle carries the old epoch and is dropped on return.
      if (jump_hit) begin
        fetch_pc <= jump_target;
        epoch    <= ~epoch;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  // 16-bit PC instance for the wrap-around case
  logic        redir16;
  logic [15:0] redir_pc16;
  logic        req16;
  logic [13:0] addr16;
  logic [31:0] rdata16;
  logic        valid16;
  logic        ready16;
  logic [31:0] instr16;
  logic [15:0] pc16;
  logic [15:0] pc4_16;

  logic        jmode;
  exp_t        sb[$];
  int          checks;
  int          errors;

  ifetch_queue #(.ADDR_W(32), .ROM_AW(14), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  ifetch_queue #(.ADDR_W(16), .ROM_AW(14), .DEPTH(4), .RESET_PC(0)) dut16 (
    .clk(clk), .reset(reset),
    .redirect_valid(redir16), .redirect_pc(redir_pc16),
    .imem_req(req16), .imem_addr(addr16), .imem_rdata(rdata16),
    .out_valid(valid16), .out_ready(ready16), .out_instr(instr16),
    .out_pc(pc16), .out_pc_plus4(pc4_16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word i holds i; in jump mode word 2 holds "j 0x20".
  function automatic logic [31:0] rom_word(input logic [13:0] a);
    if (jmode && a == 14'd2) return 32'h0800_0020;
    return {18'b0, a};
  endfunction

  always @(posedge clk) begin
    imem_rdata <= rom_word(imem_addr);
    rdata16    <= rom_word(addr16);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    sb.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    redir16 = 1'b0;
    redir_pc16 = '0;
    next();
    next();
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    check("rst_pc4", out_pc_plus4, 4);
    check("rst_req", imem_req, 0);
    check("rst_valid16", valid16, 0);
    check("rst_pc4_16", pc4_16, 4);
  endtask

  // Monitor: every accepted head entry is compared with the scoreboard.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pc %h instr %h expected none", out_pc, out_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
        check("out_pc_plus4", out_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    jmode = 1'b0;
    ready16 = 1'b1;

    // Streaming from reset, out_ready held high
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(32'(4 * i), 32'(i));
    for (int c = 0; c < 10; c++) begin
      reset = 1'b0;
      out_ready = 1'b1;
      #1;
      if (c == 0) begin
        check("p1_req_c0", imem_req, 1);
        check("p1_addr_c0", imem_addr, 0);
      end
      if (c < 2) check("p1_valid_early", out_valid, 0);
      if (c == 2) check("p1_valid_c2", out_valid, 1);
      next();
    end
    check("p1_drained", sb.size(), 0);

    // Back-pressure: credits run out at four, then release
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(32'(4 * i), 32'(i));
    for (int c = 0; c < 18; c++) begin
      reset = 1'b0;
      out_ready = (c >= 10);
      #1;
      if (c == 3) begin
        check("p2_req_c3", imem_req, 1);
        check("p2_addr_c3", imem_addr, 3);
      end
      if (c >= 4 && c <= 9) check("p2_req_stalled", imem_req, 0);
      if (c == 9) begin
        check("p2_valid_full", out_valid, 1);
        check("p2_head_pc", out_pc, 0);
      end
      if (c == 10) check("p2_req_no_pop_credit", imem_req, 0);
      if (c == 11) begin
        check("p2_req_c11", imem_req, 1);
        check("p2_addr_c11", imem_addr, 4);
      end
      if (c >= 10) check("p2_no_gap", out_valid, 1);
      next();
    end
    check("p2_drained", sb.size(), 0);

    // Redirect to 0x40 with three entries queued and a fetch in flight
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(32'h40 + 32'(4 * i), 32'h10 + 32'(i));
    for (int c = 0; c < 11; c++) begin
      reset = 1'b0;
      redirect_valid = (c == 4);
      redirect_pc = 32'h40;
      out_ready = (c >= 5);
      #1;
      if (c == 4) begin
        check("p3_valid_before", out_valid, 1);
        check("p3_req_during", imem_req, 0);
      end
      if (c == 5) begin
        check("p3_req_c5", imem_req, 1);
        check("p3_addr_c5", imem_addr, 32'h10);
      end
      if (c == 5 || c == 6) check("p3_no_stale", out_valid, 0);
      if (c == 7) check("p3_valid_c7", out_valid, 1);
      next();
    end
    check("p3_drained", sb.size(), 0);

    // Redirect and pop together on a full queue, misaligned target
    do_reset();
    for (int i = 0; i < 3; i++) push_exp(32'h100 + 32'(4 * i), 32'h40 + 32'(i));
    for (int c = 0; c < 11; c++) begin
      reset = 1'b0;
      redirect_valid = (c == 5);
      redirect_pc = 32'h103;
      out_ready = (c >= 5);
      #1;
      if (c == 5) check("p4_full", out_valid, 1);
      if (c == 6) begin
        check("p4_req_c6", imem_req, 1);
        check("p4_addr_c6", imem_addr, 32'h40);
      end
      if (c == 6 || c == 7) check("p4_flushed", out_valid, 0);
      next();
    end
    check("p4_drained", sb.size(), 0);

    // Back-to-back redirects: the second one wins
    do_reset();
    for (int i = 0; i < 3; i++) push_exp(32'h300 + 32'(4 * i), 32'hC0 + 32'(i));
    for (int c = 0; c < 9; c++) begin
      reset = 1'b0;
      out_ready = 1'b1;
      redirect_valid = (c == 2 || c == 3);
      redirect_pc = (c == 2) ? 32'h200 : 32'h300;
      #1;
      if (c == 4) check("p5_addr_c4", imem_addr, 32'hC0);
      if (c == 4 || c == 5) check("p5_empty", out_valid, 0);
      if (c == 6) check("p5_valid_c6", out_valid, 1);
      next();
    end
    check("p5_drained", sb.size(), 0);

    // 16-bit PC wraps from 0xFFFC to 0x0000
    do_reset();
    for (int c = 0; c < 5; c++) begin
      reset = 1'b0;
      redir16 = (c == 0);
      redir_pc16 = 16'hFFFC;
      #1;
      if (c == 0) check("p6_req_c0", req16, 0);
      if (c == 1) check("p6_addr_c1", addr16, 32'h3FFF);
      if (c == 2) check("p6_valid_c2", valid16, 0);
      if (c == 3) begin
        check("p6_valid_c3", valid16, 1);
        check("p6_pc_c3", pc16, 32'hFFFC);
        check("p6_instr_c3", instr16, 32'h3FFF);
        check("p6_pc4_c3", pc4_16, 32'h0000);
      end
      if (c == 4) begin
        check("p6_pc_c4", pc16, 32'h0000);
        check("p6_instr_c4", instr16, 32'h0000);
        check("p6_pc4_c4", pc4_16, 32'h0004);
      end
      next();
    end

    // j 0x20 at ROM word 2
    jmode = 1'b1;
    do_reset();
    push_exp(32'h0, 32'h0);
    push_exp(32'h4, 32'h1);
    push_exp(32'h8, 32'h0800_0020);
`ifdef IFQ_PREDECODE_JUMP_EN
    push_exp(32'h80, 32'h20);
`else
    push_exp(32'hC, 32'h3);
    push_exp(32'h10, 32'h4);
`endif
    for (int c = 0; c < 7; c++) begin
      reset = 1'b0;
      out_ready = 1'b1;
      #1;
`ifdef IFQ_PREDECODE_JUMP_EN
      if (c == 4) check("p7_addr_c4", imem_addr, 32'h20);
      if (c == 5) check("p7_bubble_c5", out_valid, 0);
`else
      if (c == 4) check("p7_addr_c4", imem_addr, 32'h4);
      if (c == 5) check("p7_valid_c5", out_valid, 1);
`endif
      next();
    end
    check("p7_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised instruction-fetch front end for the MIPS CPU.
- Owns the PC register and issues sequential word fetches to a synchronous 1-cycle-latency instruction ROM.
- Buffers returned instructions with their PC in a DEPTH-entry queue, delivered over a valid/ready handshake to decode.
- Branch/jr redirects from execute flush the queue and discard any in-flight fetch.

Parameters:
- ADDR_W, 32: PC width in bits.
- ROM_AW, 14: ROM word-address width; imem_addr = fetch_pc[ROM_AW+1:2].
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 0: PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  taken branch/jr from execute; flush and restart.
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] ignored and forced to 0.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ROM_AW  word address of the request.
- imem_rdata  in  32  ROM data; valid in the cycle after imem_req.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts the head entry.
- out_instr  out  32  head instruction.
- out_pc  out  ADDR_W  head PC.
- out_pc_plus4  out  ADDR_W  head PC + 4 (link address / branch base).

Behaviour:
- Reset, at an edge with reset=1:
  - fetch_pc <= RESET_PC; count <= 0; inflight <= 0; epoch <= 0.
  - All queue storage <= 0, so out_valid=0, out_instr=0, out_pc=0 and out_pc_plus4=4 after reset.
  - imem_req=0 while reset=1.
  - Reset asserted mid-operation drops the queue and the in-flight fetch in the same edge.
- Issue (combinational):
  - imem_req = !reset && !redirect_valid && (count + inflight < DEPTH); no credit is taken for a same-cycle pop.
  - On issue: fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W; inflight <= 1 tagged with the current epoch.
  - Otherwise inflight <= 0.
- Return:
  - In the cycle after an issue, imem_rdata is pushed with its PC if the tag equals epoch and redirect_valid=0.
  - Otherwise the return is discarded.
  - The credit rule guarantees a push never overflows.
- Pop: on out_valid && out_ready the head is removed. Push and pop in the same cycle keep count unchanged, including when the queue is full.
- Empty: out_valid=0; out_instr/out_pc hold stale storage contents and are don't-care.
- Redirect, asserted in cycle N:
  - Highest priority; any pop or push in cycle N is ignored.
  - At the edge: count <= 0, epoch toggles, fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}, inflight <= 0.
  - First new request in N+1, data in N+2, out_valid=1 in N+3.
  - Back-to-back redirects: the last one wins.
- Startup latency: first cycle with reset low = cycle 0; request in cycle 0, out_valid=1 in cycle 2.
- Steady state: one instruction per cycle with out_ready held at 1.

Optional Feature:
- Macro: IFQ_PREDECODE_JUMP_EN.
- When defined, a non-discarded return with opcode imem_rdata[31:26] = 6'b000010 (j) or 6'b000011 (jal):
  - is pushed normally;
  - at the same edge sets fetch_pc <= {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00} and toggles epoch, so the sequential fetch issued that cycle is discarded.
- External redirect_valid in the same cycle overrides this.
- Without the macro, j/jal are fetched sequentially and execute must redirect them.

Test Plan:
- Reset, RESET_PC=0, ROM word i = i, out_ready=1 -> out_valid rises in cycle 2; out_pc = 0, 4, 8, ... one per cycle; out_instr = 0, 1, 2; out_pc_plus4 = out_pc + 4.
- out_ready=0 for 10 cycles, DEPTH=4 -> imem_req drops once count + inflight = 4; queue holds PCs 0x0-0xC; on release, 0x10 follows with no gap or duplicate.
- Redirect to 0x40 while the queue holds 3 entries and a fetch is in flight -> no stale entry ever visible; out_valid=1 three cycles later with out_pc=0x40.
- redirect_valid and out_ready asserted together on a full queue, redirect_pc=0x103 -> flush wins; next out_pc=0x100.
- ADDR_W=16, redirect to 0xFFFC -> out_pc sequence 0xFFFC, 0x0000 (wrap).
- IFQ_PREDECODE_JUMP_EN with ROM[2] = j 0x20 -> out_pc sequence 0x0, 0x4, 0x8, 0x80; PC 0xC is never delivered.
- Same ROM without the macro -> out_pc sequence 0x0, 0x4, 0x8, 0xC.
